// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: operation encodings used by the control
// unit for decode and by md_unit for execution.
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Codes 0-3 are the multi-cycle arithmetic ops; everything above is a move or reserved.
  function automatic logic is_arith_op(input logic [MD_OP_W-1:0] op);
    return !op[MD_OP_W-1];
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath: full-width products, truncating
// division with dividend-signed remainder, divide-by-zero flag.
module md_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo,
  output logic               div_zero
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic signed [W2-1:0]    sprod;
  logic [W2-1:0]           uprod;
  logic                    b_zero;
  logic                    sdiv_ovf;

  assign sa       = $signed(a);
  assign sb       = $signed(b);
  assign sprod    = W2'(sa) * W2'(sb);
  assign uprod    = W2'(a) * W2'(b);
  assign b_zero   = (b == '0);
  // min / -1 does not fit; the architected answer is lo = min, hi = 0.
  assign sdiv_ovf = (a == MIN_VAL) && (b == '1);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = sprod;
      MD_MULTU: {res_hi, res_lo} = uprod;
      MD_DIV: begin
        if (b_zero) begin
          div_zero = 1'b1;
        end else if (sdiv_ovf) begin
          res_lo = MIN_VAL;
        end else begin
          res_lo = sa / sb;
          res_hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          div_zero = 1'b1;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: latency counter, pending result, HI/LO
// registers and the D-stage stall request.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_E,
  input  logic               wr_E,
  input  logic [MD_OP_W-1:0] md_op_E,
  input  logic [WIDTH-1:0]   src_a_E,
  input  logic [WIDTH-1:0]   src_b_E,
  input  logic               md_use_D,
  output logic               busy,
  output logic               stall_D,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_dz;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;
  logic             start_ok;
  logic             finish;

  md_core #(.WIDTH(WIDTH)) u_core (
    .op       (md_op_E),
    .a        (src_a_E),
    .b        (src_b_E),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign busy     = (cnt != '0);
  assign stall_D  = md_use_D & (start_E | busy);
  assign start_ok = start_E & ~busy & is_arith_op(md_op_E);
  assign finish   = (cnt == CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (start_ok) begin
        cnt     <= is_div_op(md_op_E) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_dz <= div_zero;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end

      // A committing result overrides a same-cycle move; a start drops any move.
      if (finish && !pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (wr_E && !start_E) begin
        if (md_op_E == MD_MTHI) hi <= src_a_E;
        if (md_op_E == MD_MTLO) lo <= src_a_E;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases from the block's rules plus
// randomized ops against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic        wr_E;
  logic [2:0]  md_op_E;
  logic [31:0] src_a_E;
  logic [31:0] src_b_E;
  logic        md_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_E  (start_E),
    .wr_E     (wr_E),
    .md_op_E  (md_op_E),
    .src_a_E  (src_a_E),
    .src_b_E  (src_b_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_D  (stall_D),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the operands.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      3'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      3'd3: if (b != 0) begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_E  = 1'b0;
    wr_E     = 1'b0;
    md_op_E  = 3'd7;
    src_a_E  = '0;
    src_b_E  = '0;
    md_use_D = 1'b0;
  endtask

  // One arithmetic op, checked cycle by cycle with md_use_D held high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    logic [31:0] old_h, old_l;
    n = (op < 3'd2) ? 5 : 10;
    old_h = exp_hi;
    old_l = exp_lo;
    md_op_E = op; src_a_E = a; src_b_E = b; start_E = 1'b1; md_use_D = 1'b1;
    #1;
    n_cmp++;
    if (stall_D !== 1'b1) begin n_bad++; $display("FAIL %s start-cycle stall_D got %b want 1", tag, stall_D); end
    tick();
    start_E = 1'b0;
    src_a_E = $urandom; src_b_E = $urandom; md_op_E = 3'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || stall_D !== 1'b1) begin
        n_bad++; $display("FAIL %s busy cycle %0d busy=%b stall_D=%b want 1/1", tag, i + 1, busy, stall_D);
      end
      n_cmp++;
      if (hi !== old_h || lo !== old_l) begin
        n_bad++; $display("FAIL %s early update cycle %0d hi=%h lo=%h want %h %h", tag, i + 1, hi, lo, old_h, old_l);
      end
      tick();
    end
    model(op, a, b, exp_hi, exp_lo);
    n_cmp++;
    if (busy !== 1'b0 || stall_D !== 1'b0) begin
      n_bad++; $display("FAIL %s done busy=%b stall_D=%b want 0/0", tag, busy, stall_D);
    end
    n_cmp++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_bad++; $display("FAIL %s result hi=%h lo=%h want %h %h", tag, hi, lo, exp_hi, exp_lo);
    end
    md_use_D = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] op, input logic [31:0] val);
    md_op_E = op; src_a_E = val; wr_E = 1'b1;
    tick();
    wr_E = 1'b0;
    if (op == 3'd4) exp_hi = val;
    if (op == 3'd5) exp_lo = val;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    md_use_D = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_bad++; $display("FAIL reset busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    n_cmp++;
    if (stall_D !== 1'b0) begin n_bad++; $display("FAIL reset stall_D got %b want 0", stall_D); end
    md_use_D = 1'b0;
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, "mult_neg1x2");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL mult_const hi=%h lo=%h want ffffffff fffffffe", hi, lo);
    end
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu_x2");
    n_cmp++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL multu_const hi=%h lo=%h want 00000001 fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_bad++; $display("FAIL div_const hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    run_op(3'd3, 32'd7, 32'd2, "divu_7by2");
    n_cmp++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      n_bad++; $display("FAIL divu_const hi=%h lo=%h want 1 3", hi, lo);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    n_cmp++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_bad++; $display("FAIL div_ovf_const hi=%h lo=%h want 0 80000000", hi, lo);
    end
  endtask

  task automatic test_moves();
    logic [31:0] h0;
    h0 = exp_hi;
    do_move(3'd5, 32'h0000_ABCD);
    n_cmp++;
    if (lo !== 32'h0000_ABCD || hi !== h0) begin
      n_bad++; $display("FAIL mtlo lo=%h hi=%h want 0000abcd %h", lo, hi, h0);
    end
    do_move(3'd4, 32'h11);
    do_move(3'd5, 32'h22);
    n_cmp++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_bad++; $display("FAIL mthi_mtlo hi=%h lo=%h want 11 22", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    run_op(3'd2, 32'd1234, 32'd0, "div_by_zero");
    n_cmp++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_bad++; $display("FAIL divzero_const hi=%h lo=%h want 11 22", hi, lo);
    end
    run_op(3'd3, 32'hDEAD_BEEF, 32'd0, "divu_by_zero");
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    md_op_E = 3'd0; src_a_E = 32'd3; src_b_E = 32'd5; start_E = 1'b1; md_use_D = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (stall_D === 1'b1) stalls++;
      tick();
      start_E = 1'b0;
    end
    #1;
    n_cmp++;
    if (stall_D !== 1'b0 || stalls != 6) begin
      n_bad++; $display("FAIL stall_window stall cycles=%0d final stall_D=%b want 6 / 0", stalls, stall_D);
    end
    model(3'd0, 32'd3, 32'd5, exp_hi, exp_lo);
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, "back_to_back");
  endtask

  task automatic test_start_and_write();
    md_op_E = 3'd0; src_a_E = 32'hFFFF_FFFD; src_b_E = 32'd4; start_E = 1'b1; wr_E = 1'b1;
    tick();
    start_E = 1'b0; wr_E = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    model(3'd0, 32'hFFFF_FFFD, 32'd4, exp_hi, exp_lo);
    n_cmp++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_bad++; $display("FAIL start_and_write busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_write_while_busy();
    md_op_E = 3'd3; src_a_E = 32'd100; src_b_E = 32'd7; start_E = 1'b1;
    tick();
    start_E = 1'b0;
    tick();
    do_move(3'd4, 32'h55);
    n_cmp++;
    if (hi !== 32'h55 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mthi_busy hi=%h busy=%b want 55 1", hi, busy);
    end
    for (int i = 0; i < 8; i++) tick();
    model(3'd3, 32'd100, 32'd7, exp_hi, exp_lo);
    n_cmp++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_bad++; $display("FAIL commit_after_move busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid();
    md_op_E = 3'd2; src_a_E = 32'd50; src_b_E = 32'd3; start_E = 1'b1;
    tick();
    start_E = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_bad++; $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_bad++; $display("FAIL reset_no_commit busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) do_move(3'($urandom_range(4, 5)), $urandom);
      run_op(op, a, b, "random");
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_mult();
    test_div();
    test_moves();
    test_div_zero();
    test_back_to_back();
    test_start_and_write();
    test_write_while_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the five-stage pipeline beside the ALU. It accepts signed and unsigned multiply/divide requests and HI/LO moves, and models configurable latency with a busy counter. It also produces the D-stage stall request consumed by the conflict logic. Width and latencies are parameters, so the same block serves the current 32-bit core and its later variants.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- start_E  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU this cycle
- wr_E  in  1  E-stage instruction is MTHI/MTLO this cycle
- md_op_E  in  3  operation code (see Operation)
- src_a_E  in  WIDTH  forwarded rs value
- src_b_E  in  WIDTH  forwarded rt value
- md_use_D  in  1  D-stage instruction is any MDU instruction (incl. MFHI/MFLO)
- busy  out  1  operation in flight
- stall_D  out  1  md_use_D & (start_E | busy)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- md_op encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, ignored.
- Start accepted when start_E=1 and busy=0. Operands and op are latched, and the result is computed into internal pending_hi/pending_lo. The counter is loaded with MULT_CYCLES or DIV_CYCLES.
- MULT: {hi,lo} = signed(a)*signed(b), full 2*WIDTH product. MULTU: unsigned product.
- DIV: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend. DIVU: unsigned quotient and remainder.
- Divide by zero: the op runs its full latency, and HI/LO remain unchanged at completion.
- Signed overflow (min / -1): lo = min, hi = 0.
- Completion: the counter decrements each cycle while busy. On the edge where the counter goes 1→0, hi/lo load the pending values and busy falls.
- MTHI/MTLO (wr_E=1, busy=0): hi or lo is written with src_a_E at the next edge.
- Start while busy: ignored. The pipeline prevents this via stall_D.
- MTHI/MTLO while busy: the write is applied immediately. The pending result still overwrites both registers at completion.
- start_E and wr_E asserted together: start_E wins, and the write is dropped.
- MFHI/MFLO are not handled here. The datapath reads hi/lo directly once stall_D is low.

## Timing
- Reset values: busy=0, counter=0, hi=0, lo=0, pending=0. stall_D is combinational from md_use_D and start_E.
- start_E sampled high at edge t: busy is 1 for cycles t+1 … t+N, where N is the op latency.
- hi/lo show the result from cycle t+N+1, which is also the first cycle with busy=0.
- A back-to-back start is possible in cycle t+N+1.
- stall_D is combinational. It is high in the start cycle and in all busy cycles whenever md_use_D=1.
- Reset mid-operation: at the next edge the op is aborted, busy=0, and hi=lo=0. The pending result is never committed.
- Counter width: clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Structure
- Shared package md_pkg holds the md_op encodings (MD_MULT … MD_MTLO) and MD_OP_W=3. The control unit also imports it for decode.
- One sub-module, md_core, is combinational. It takes op, a and b, and produces {res_hi,res_lo,div_zero}.
- md_unit itself holds the counter, busy, pending registers, HI/LO and stall logic.

## Test plan
- MULT a=0xFFFFFFFF (-1), b=2 → after 5 busy cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7, b=2 → busy exactly 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 → lo=3, hi=1.
- DIV by zero with hi=0x11, lo=0x22 preset via MTHI/MTLO → after 10 cycles, hi=0x11, lo=0x22, busy=0.
- md_use_D held at 1 across a MULT → stall_D is high in the start cycle plus 5 busy cycles (6 total), then low. A second start in cycle t+6 is accepted.
- reset asserted at busy cycle 3 of a DIV → next cycle busy=0, hi=lo=0, and no later update occurs.
- MTLO 0xABCD with busy=0 → lo=0xABCD on the next cycle, hi unchanged. start_E and wr_E asserted together → only the multiply takes effect.
